spram_arbiter: RTL
==================

# spram_arbiter

Two-requester arbiter and sequencer for the simple dual-port RAM: one registered-address read port, one synchronous write port, 64 x 14 by default. After reset it sweeps the whole array to a known value, then shares the two RAM ports between two requesters over valid/ready request channels. It returns read data with a fixed one-cycle latency. A read from one requester and a write from the other are served in the same cycle.

## Interface
- ADDR_WIDTH, 6: RAM address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 14: RAM word width.
- INIT_VALUE, 0: word written to every location during the init sweep.

Ports (N in {0,1}):
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- reqN_valid  in  1  requester N presents a request.
- reqN_ready  out  1  request accepted on this edge when valid is also high.
- reqN_write  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  target address.
- reqN_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rspN_valid  out  1  read data for requester N is on rspN_rdata this cycle.
- rspN_rdata  out  DATA_WIDTH  read data (equals mem_rd_data).
- init_done  out  1  sweep complete; requests may be accepted.
- mem_rd_addr  out  ADDR_WIDTH  to RAM read-port address; the RAM registers it.
- mem_rd_data  in  DATA_WIDTH  from RAM read-port output.
- mem_wr_addr  out  ADDR_WIDTH  to RAM write-port address.
- mem_wr_data  out  DATA_WIDTH  to RAM write-port data.
- mem_wr_en  out  1  to RAM write enable.

## Operation
- FSM states: IDLE (reset state), INIT, RUN.
  - IDLE -> INIT unconditionally on the first edge.
  - INIT -> RUN on the edge that writes the last address.
  - RUN is terminal.
- IDLE: mem_wr_en=0, all ready=0.
- INIT:
  - mem_wr_en=1, mem_wr_addr = sweep counter (0 up to 2^ADDR_WIDTH-1), mem_wr_data=INIT_VALUE.
  - All ready=0.
  - The counter is exactly ADDR_WIDTH+1 bits wide; no wrap is permitted.
- RUN: read-port and write-port arbitration are independent.
  - Read candidates are requesters with valid=1, write=0. Write candidates are requesters with valid=1, write=1.
  - A single candidate on a port is granted.
  - Two candidates on a port: the winner is chosen per Configuration. The loser's ready=0 and it must hold its request.
  - reqN_ready is combinational from both requesters' valid/write and the arbitration state. It may depend on its own valid.
- Granted write: mem_wr_en=1 with that requester's addr/wdata.
- No granted write: mem_wr_en=0; mem_wr_addr and mem_wr_data are don't-care but are driven to 0.
- Granted read: mem_rd_addr = winner's addr.
- No granted read: mem_rd_addr holds 0.
- Response path:
  - A registered one-hot tag records the read winner.
  - rspN_valid = tag[N] in the following cycle.
  - rsp0_rdata = rsp1_rdata = mem_rd_data.
  - Responses have no backpressure.
- Same-address read and write in one cycle (from different requesters) is write-first: the read response carries the newly written word.
- Reset mid-operation returns to IDLE, restarts the sweep and drops any pending response.

## Timing
- Reset values: ready=0, rspN_valid=0, init_done=0, mem_wr_en=0, mem_rd_addr=0, tag=0, sweep counter=0.
- After reset release:
  - Edge 1: IDLE -> INIT.
  - Edges 2..2^ADDR_WIDTH+1 perform the writes.
  - init_done=1 from the following cycle. This is 65 cycles of latency at default parameters.
- Read latency:
  - Read accepted at edge T.
  - rspN_valid=1 and valid data during cycle T+1, observed at edge T+1.
- Write visible to a read accepted at the same or any later edge.
- Throughput: one read and one write per cycle in aggregate.

## Configuration
- SPRAM_ARB_RR_EN defined: round-robin.
  - One priority pointer per port, reset to requester 0.
  - Toggles only after a contested grant on that port, pointing at the loser.
- Undefined: fixed priority; requester 0 always wins contention and no pointer registers exist.

## Structure
- Shared package: state enum (IDLE, INIT, RUN), default ADDR_WIDTH/DATA_WIDTH constants, and a request struct (write, addr, wdata).
- One sub-module: spram_arb2. This is a 2-way grant unit (two requests in, one-hot grant out, optional pointer under the macro), instantiated once per RAM port.

## Test plan
- Reset release with no requests -> 64 writes of INIT_VALUE to addresses 0..63 on consecutive cycles; init_done high cycle 65; ready low throughout; every read then returns 0.
- req0 writes 0x1ABC to addr 5, next cycle req1 reads addr 5 -> rsp1_valid one cycle after acceptance with rdata 0x1ABC; rsp0_valid stays 0.
- Same cycle: req0 reads addr 9, req1 writes 0x0033 to addr 9 -> both ready=1; rsp0_rdata = 0x0033 next cycle.
- Both read continuously at addresses 1 and 2 for 6 cycles:
  - With SPRAM_ARB_RR_EN -> grants alternate 0,1,0,1,...
  - Without -> req0 granted every cycle, req1 ready=0.
- Both write same cycle to addr 7 (0x0001, 0x0002) -> one write per cycle in arbitration order; final read of addr 7 returns the later winner's data.
- rst_n pulsed low during sweep at address 30 and again with a read in flight -> rsp_valid dropped, init_done=0, sweep restarts from address 0 and completes in full.

Source files
------------

// File: rtl/spram_arbiter_pkg.sv
// spram_arbiter_pkg: shared types and defaults for the two-requester RAM
// arbiter. The optional round-robin mode is selected with SPRAM_ARB_RR_EN.
package spram_arbiter_pkg;

  // Default geometry of the attached RAM (64 x 14).
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 14;

  // Request struct fields are sized to the widest geometry the arbiter
  // supports; narrower instances zero-extend into it and truncate out of it.
  localparam int REQ_ADDR_MAX = 16;
  localparam int REQ_DATA_MAX = 32;

  // Sequencer states: IDLE only lasts one edge after reset, INIT sweeps
  // the array, RUN arbitrates forever.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // One requester's command as seen by the write-port mux.
  typedef struct packed {
    logic                    write;
    logic [REQ_ADDR_MAX-1:0] addr;
    logic [REQ_DATA_MAX-1:0] wdata;
  } req_t;

endpackage

// File: rtl/spram_arb2.sv
// spram_arb2: 2-way grant unit. Two requests in, one-hot grant out.
// With SPRAM_ARB_RR_EN defined a one-bit priority pointer alternates the
// winner after each contested grant; otherwise requester 0 always wins.
module spram_arb2
  import spram_arbiter_pkg::*;
(
`ifdef SPRAM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

`ifdef SPRAM_ARB_RR_EN
  // 0: requester 0 has priority on contention, 1: requester 1 has priority.
  logic r_ptr;

  // Pick the winner; the pointer only matters when both request.
  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = r_ptr ? 2'b10 : 2'b01;
    end
  end

  // After a contested grant point at the loser so it wins next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (&i_req) begin
      r_ptr <= o_gnt[0];
    end
  end
`else
  // Fixed priority: requester 0 wins any contention.
  always_comb begin
    o_gnt = {i_req[1] & ~i_req[0], i_req[0]};
  end
`endif

endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter: sweeps a simple dual-port RAM to INIT_VALUE after reset,
// then shares its read port and write port between two valid/ready
// requesters. Read data returns one cycle after acceptance.
// Optional round-robin arbitration: define SPRAM_ARB_RR_EN.
//
// Handshake: a request transfers on the rising edge where reqN_valid and
// reqN_ready are both high. A requester that sees ready low keeps valid,
// write, addr and wdata stable until it is accepted. Responses have no
// backpressure: rspN_valid is high for exactly one cycle per accepted read.
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en
);

  // The sweep counter carries one extra bit so that reaching the last
  // address never relies on wrap-around.
  localparam logic [ADDR_WIDTH:0] SWEEP_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] SWEEP_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                r_state;
  logic [ADDR_WIDTH:0]   r_sweep;
  logic [1:0]            r_tag;
  logic                  r_init_done;

  logic                  w_run;
  req_t                  w_req0;
  req_t                  w_req1;
  req_t                  w_wr_sel;
  logic [1:0]            w_rd_cand;
  logic [1:0]            w_wr_cand;
  logic [1:0]            w_gnt_rd;
  logic [1:0]            w_gnt_wr;

  assign w_run = (r_state == ST_RUN);

  // Gather each requester's command into the shared request struct.
  always_comb begin
    w_req0       = '0;
    w_req0.write = req0_write;
    w_req0.addr  = REQ_ADDR_MAX'(req0_addr);
    w_req0.wdata = REQ_DATA_MAX'(req0_wdata);
    w_req1       = '0;
    w_req1.write = req1_write;
    w_req1.addr  = REQ_ADDR_MAX'(req1_addr);
    w_req1.wdata = REQ_DATA_MAX'(req1_wdata);
  end

  // Split valid requests into read and write candidates; nothing is a
  // candidate until the sweep has finished.
  always_comb begin
    w_rd_cand = '0;
    w_wr_cand = '0;
    if (w_run) begin
      w_rd_cand = {req1_valid & ~w_req1.write, req0_valid & ~w_req0.write};
      w_wr_cand = {req1_valid &  w_req1.write, req0_valid &  w_req0.write};
    end
  end

  spram_arb2 u_arb_rd (
`ifdef SPRAM_ARB_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .i_req (w_rd_cand),
    .o_gnt (w_gnt_rd)
  );

  spram_arb2 u_arb_wr (
`ifdef SPRAM_ARB_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .i_req (w_wr_cand),
    .o_gnt (w_gnt_wr)
  );

  // A requester is ready exactly when it holds the grant on its port.
  assign req0_ready = w_gnt_rd[0] | w_gnt_wr[0];
  assign req1_ready = w_gnt_rd[1] | w_gnt_wr[1];

  // Read port: winner's address, or 0 when nobody reads.
  always_comb begin
    mem_rd_addr = '0;
    if (w_gnt_rd[0]) begin
      mem_rd_addr = req0_addr;
    end else if (w_gnt_rd[1]) begin
      mem_rd_addr = req1_addr;
    end
  end

  assign w_wr_sel = w_gnt_wr[1] ? w_req1 : w_req0;

  // Write port: sweep writes during INIT, granted writes during RUN.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (r_state == ST_INIT) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = r_sweep[ADDR_WIDTH-1:0];
      mem_wr_data = INIT_VALUE;
    end else if (|w_gnt_wr) begin
      mem_wr_en   = w_wr_sel.write;
      mem_wr_addr = ADDR_WIDTH'(w_wr_sel.addr);
      mem_wr_data = DATA_WIDTH'(w_wr_sel.wdata);
    end
  end

  // Sequencer: IDLE -> INIT sweep -> RUN, plus the read-response tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sweep     <= '0;
      r_tag       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_tag <= w_gnt_rd;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_INIT;
        end
        ST_INIT: begin
          r_sweep <= r_sweep + SWEEP_ONE;
          if (r_sweep == SWEEP_LAST) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign init_done  = r_init_done;
  assign rsp0_valid = r_tag[0];
  assign rsp1_valid = r_tag[1];
  assign rsp0_rdata = mem_rd_data;
  assign rsp1_rdata = mem_rd_data;

endmodule
